// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the rv32i fetch stage.
// fetch_entry_t is one buffered instruction: the PC it was fetched from and
// the returned instruction word.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h6000_0000;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH-entry circular buffer of fetch_entry_t.
// Head entry is read combinationally from the storage registers. Flush
// empties the buffer and wins over a same-cycle push/pop. A push while
// full is accepted only together with a pop (the freed head slot is the
// tail slot).
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  head_ptr_reg;
  logic [PW-1:0]  tail_ptr_reg;
  logic [PW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign full      = (count_reg == (PW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[head_ptr_reg];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr_reg] <= push_data;
        tail_ptr_reg      <= tail_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        head_ptr_reg <= head_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: rv32i fetch stage. Generates sequential PCs, keeps at most
// one imem request in flight, buffers returned words in a DEPTH-entry queue
// and presents them to decode over out_valid/out_ready. A redirect flushes
// the queue and marks any still-pending response for discard.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- a response arriving at an
// empty queue is presented to decode in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_en,
  input  logic [31:0] br,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(DEPTH);

  logic [31:0]  pc_reg;
  logic [31:0]  inflight_pc_reg;
  logic         outstanding_reg;
  logic         discard_reg;

  logic         resp_ok;
  logic         inflight_keep;
  logic [CW:0]  occupancy;
  logic         issue;
  logic         push_resp;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW:0]  fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t resp_entry;

  // A response only counts when it answers our single outstanding request
  assign resp_ok       = imem_resp && outstanding_reg;
  // An in-flight word that will land in the queue already owns a slot
  assign inflight_keep = outstanding_reg && !discard_reg;
  assign occupancy     = fifo_count + {{CW{1'b0}}, inflight_keep};
  // A discard-pending request keeps outstanding high, so it blocks issue
  // until its response returns
  assign issue         = !rst && !br_en && (!outstanding_reg || resp_ok) &&
                         (occupancy < (CW+1)'(DEPTH));
  // Responses coinciding with a redirect are stale and dropped
  assign push_resp     = resp_ok && !discard_reg && !br_en;
  assign resp_entry    = '{pc: inflight_pc_reg, inst: imem_rdata};

  assign imem_addr     = pc_reg;
  assign imem_rmask    = issue ? 4'b1111 : 4'b0000;

  // PC, in-flight PC capture and outstanding/discard tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      inflight_pc_reg <= '0;
      outstanding_reg <= 1'b0;
      discard_reg     <= 1'b0;
    end else begin
      if (br_en) begin
        pc_reg <= br;
      end else if (issue) begin
        pc_reg <= pc_reg + 32'd4;
      end
      if (issue) begin
        inflight_pc_reg <= pc_reg;
      end
      if (issue) begin
        outstanding_reg <= 1'b1;
      end else if (resp_ok) begin
        outstanding_reg <= 1'b0;
      end
      if (resp_ok) begin
        discard_reg <= 1'b0;
      end else if (br_en && outstanding_reg) begin
        discard_reg <= 1'b1;
      end
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // Empty queue: forward the arriving word straight to decode
  always_comb begin
    bypass    = push_resp && fifo_empty;
    out_valid = !fifo_empty || bypass;
    out_pc    = bypass ? inflight_pc_reg : fifo_head.pc;
    out_inst  = bypass ? imem_rdata      : fifo_head.inst;
    fifo_push = push_resp && !(bypass && out_ready);
    fifo_pop  = out_ready && !fifo_empty;
  end
`else
  // Every word is written first; decode sees only the registered head
  always_comb begin
    out_valid = !fifo_empty;
    out_pc    = fifo_head.pc;
    out_inst  = fifo_head.inst;
    fifo_push = push_resp;
    fifo_pop  = out_ready && !fifo_empty;
  end
`endif

  fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .flush     (br_en),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Protocol checks: no unsolicited responses, credit rule never overfills
  assert property (@(posedge clk) disable iff (rst)
    !(imem_resp && !outstanding_reg));
  assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop && !br_en));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized + directed bench for fetch_queue against a
// queue-based reference model of the fetch stream.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_en;
  logic [31:0] br;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_en      (br_en),
    .br         (br),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_inflight;
  bit           m_out;
  bit           m_disc;

  // imem responder
  bit           pend;
  int           resp_cyc;
  logic [31:0]  resp_addr;
  int           lat_min;
  int           lat_max;
  int           cyc;

  logic [31:0]  issued_q[$];
  logic [31:0]  popped_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc       = RST_PC;
    m_inflight = '0;
    m_out      = 1'b0;
    m_disc     = 1'b0;
    pend       = 1'b0;
  endtask

  // called at a negedge; returns at a negedge with rst released
  task automatic do_reset();
    rst        = 1'b1;
    br_en      = 1'b0;
    br         = '0;
    out_ready  = 1'b0;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    #1;
    check("rst_rmask", {28'd0, imem_rmask}, 32'h0);
    check("rst_addr",  imem_addr, RST_PC);
    check("rst_valid", {31'd0, out_valid}, 32'h0);
    check("rst_pc",    out_pc, 32'h0);
    check("rst_inst",  out_inst, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one clock cycle: drive at negedge, check, advance model, wait next negedge
  task automatic cycle(input bit b_en, input logic [31:0] b_tgt, input bit rdy);
    bit           resp_ok, issue_e, push_e, bypass_e, valid_e, pop_e;
    int           occ;
    fetch_entry_t head_e;
    br_en     = b_en;
    br        = b_tgt;
    out_ready = rdy;
    if (pend && resp_cyc == cyc) begin
      imem_resp  = 1'b1;
      imem_rdata = inst_of(resp_addr);
      pend       = 1'b0;
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    resp_ok  = imem_resp && m_out;
    occ      = m_q.size() + ((m_out && !m_disc) ? 1 : 0);
    issue_e  = !b_en && (!m_out || resp_ok) && (occ < DEPTH);
    push_e   = resp_ok && !m_disc && !b_en;
    bypass_e = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_e = push_e && (m_q.size() == 0);
`endif
    valid_e  = (m_q.size() > 0) || bypass_e;
    head_e   = '0;
    if (bypass_e) head_e = '{pc: m_inflight, inst: imem_rdata};
    else if (m_q.size() > 0) head_e = m_q[0];

    check("imem_addr",  imem_addr, m_pc);
    check("imem_rmask", {28'd0, imem_rmask}, issue_e ? 32'hF : 32'h0);
    check("out_valid",  {31'd0, out_valid}, {31'd0, valid_e});
    if (valid_e) begin
      check("out_pc",   out_pc, head_e.pc);
      check("out_inst", out_inst, head_e.inst);
    end

    if (out_valid && out_ready) begin
      popped_q.push_back(out_pc);
      $display("[TB] cyc %0d pop pc=%h inst=%h", cyc, out_pc, out_inst);
    end
    if (imem_rmask == 4'hF) begin
      issued_q.push_back(imem_addr);
      pend      = 1'b1;
      resp_addr = imem_addr;
      resp_cyc  = cyc + int'($urandom_range(lat_max, lat_min));
    end

    pop_e = valid_e && rdy;
    if (pop_e && !bypass_e) void'(m_q.pop_front());
    if (push_e && !(bypass_e && rdy)) m_q.push_back('{pc: m_inflight, inst: imem_rdata});
    if (b_en) begin
      m_q.delete();
      if (m_out && !imem_resp) m_disc = 1'b1;
    end
    if (resp_ok) begin
      m_out  = 1'b0;
      m_disc = 1'b0;
    end
    if (issue_e) begin
      m_out      = 1'b1;
      m_inflight = m_pc;
      m_pc       = m_pc + 32'd4;
    end
    if (b_en) m_pc = b_tgt;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit          found;
    int          start;
    logic [31:0] tgt;
    rst = 1'b1; br_en = 1'b0; br = '0; out_ready = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0;
    cyc = 0; lat_min = 2; lat_max = 2;
    @(negedge clk);

    // sequential fetch, fixed latency 2, decode always ready
    do_reset();
    issued_q.delete(); popped_q.delete();
    repeat (20) cycle(1'b0, 32'h0, 1'b1);
    check("seq_pops", popped_q.size(), 9);
    check("seq_pc0", popped_q.size() > 0 ? popped_q[0] : 32'hDEAD_DEAD, 32'h6000_0000);
    check("seq_pc1", popped_q.size() > 1 ? popped_q[1] : 32'hDEAD_DEAD, 32'h6000_0004);
    check("seq_pc2", popped_q.size() > 2 ? popped_q[2] : 32'hDEAD_DEAD, 32'h6000_0008);

    // decode stalled: exactly DEPTH requests, then drain and resume
    do_reset();
    issued_q.delete(); popped_q.delete();
    repeat (20) cycle(1'b0, 32'h0, 1'b0);
    check("stall_reqs", issued_q.size(), DEPTH);
    repeat (20) cycle(1'b0, 32'h0, 1'b1);
    check("drain_pc3", popped_q.size() > 3 ? popped_q[3] : 32'hDEAD_DEAD, 32'h6000_000C);
    check("resume", {31'd0, issued_q.size() > DEPTH}, 32'h1);

    // redirect while the request to 0x6000_000C is outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    issued_q.delete();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (issued_q.size() > 0 && issued_q[$] == 32'h6000_000C) found = 1'b1;
    end
    check("redir_found", {31'd0, found}, 32'h1);
    cycle(1'b1, 32'h6000_0100, 1'b1);
    issued_q.delete(); popped_q.delete();
    repeat (15) cycle(1'b0, 32'h0, 1'b1);
    check("redir_addr", issued_q.size() > 0 ? issued_q[0] : 32'hDEAD_DEAD, 32'h6000_0100);
    check("redir_pop",  popped_q.size() > 0 ? popped_q[0] : 32'hDEAD_DEAD, 32'h6000_0100);

    // redirect in the same cycle as a response
    do_reset();
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    start = cyc;
    for (int i = 0; i < 50 && !found; i++) begin
      if (pend && resp_cyc == cyc && (cyc - start) > 4) begin
        cycle(1'b1, 32'h6000_0200, 1'b1);
        found = 1'b1;
      end else begin
        cycle(1'b0, 32'h0, 1'b1);
      end
    end
    check("same_found", {31'd0, found}, 32'h1);
    issued_q.delete();
    cycle(1'b0, 32'h0, 1'b1);
    check("same_next", issued_q.size() > 0 ? issued_q[0] : 32'hDEAD_DEAD, 32'h6000_0200);
    repeat (10) cycle(1'b0, 32'h0, 1'b1);

    // randomized traffic with a mid-run reset
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle($urandom_range(99) < 3, tgt, $urandom_range(99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
